// File: rtl/tile_layer_renderer.sv
// Background tile layer renderer: fetches one tilemap word and one pattern ROM
// row per 8-pixel tile column, then shifts PLANES bits per pixel out together
// with the tile's colour bank. Supports per-tile H/V flip, a global screen flip,
// an opaque flag and detection of tile loads that find no completed fetch.
module tile_layer_renderer #(
    parameter int PLANES        = 3,
    parameter int COLOR_BITS    = 4,
    parameter int TILE_BITS     = 10,
    parameter int MAP_COLS_LOG2 = 6,
    parameter int MAP_ROWS_LOG2 = 5,
    parameter int ATTR_FLIP_EN  = 1
) (
    input  logic                                   master_clk,
    input  logic                                   reset,
    input  logic                                   pixel_ce,
    input  logic [8:0]                             hpix,
    input  logic [7:0]                             vpix,
    input  logic                                   screen_flip,
    input  logic                                   layer_en,
    output logic [MAP_ROWS_LOG2+MAP_COLS_LOG2-1:0] map_addr,
    input  logic [15:0]                            map_data,
    output logic [TILE_BITS+2:0]                   rom_addr,
    input  logic [8*PLANES-1:0]                    rom_data,
    output logic [COLOR_BITS+PLANES-1:0]           pixel_out,
    output logic                                   pixel_opaque,
    output logic                                   fetch_underrun
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        MAP_RQ = 3'd1,
        MAP_WT = 3'd2,
        ROM_RQ = 3'd3,
        ROM_WT = 3'd4
    } state_t;

    state_t state_r, state_nx_s;

    logic [2:0]            ph_s;
    logic                  trigger_s, load_s, capture_s;
    logic [TILE_BITS-1:0]  map_tile_s;
    logic [COLOR_BITS-1:0] map_color_s;
    logic                  map_hflip_s, map_vflip_s;

    logic [2:0]            vrow_r;
    logic [COLOR_BITS-1:0] fetch_color_r;
    logic                  fetch_hflip_r;

    logic                  pre_valid_r;
    logic [8*PLANES-1:0]   pre_data_r;
    logic [COLOR_BITS-1:0] pre_color_r;
    logic                  pre_hflip_r;

    logic [8*PLANES-1:0]   shift_r;
    logic [COLOR_BITS-1:0] cur_color_r;
    logic                  cur_hflip_r;
    logic                  dir_right_s;
    logic [PLANES-1:0]     pix_bits_s;

    // Advance every plane by one pixel in the current scan direction.
    function automatic logic [8*PLANES-1:0] shift_planes(input logic [8*PLANES-1:0] v,
                                                         input logic right);
        logic [8*PLANES-1:0] r;
        for (int p = 0; p < PLANES; p++) begin
            if (right) begin
                r[8*p +: 8] = {1'b0, v[8*p+1 +: 7]};
            end else begin
                r[8*p +: 8] = {v[8*p +: 7], 1'b0};
            end
        end
        return r;
    endfunction

    assign ph_s        = hpix[2:0] ^ {3{screen_flip}};
    assign trigger_s   = pixel_ce && (ph_s == 3'd0);
    assign load_s      = pixel_ce && (ph_s == 3'd7);
    // A restart in the ROM_WT cycle discards the fetch that would complete.
    assign capture_s   = (state_r == ROM_WT) && !trigger_s;
    assign map_tile_s  = map_data[TILE_BITS-1:0];
    assign map_color_s = map_data[11 +: COLOR_BITS];
    assign map_hflip_s = (ATTR_FLIP_EN != 0) ? map_data[15] : 1'b0;
    assign map_vflip_s = (ATTR_FLIP_EN != 0) ? map_data[10] : 1'b0;
    assign dir_right_s = cur_hflip_r ^ screen_flip;

    // Select the pixel currently at the output end of each plane register.
    always_comb begin
        pix_bits_s = '0;
        for (int p = 0; p < PLANES; p++) begin
            if (dir_right_s) begin
                pix_bits_s[p] = shift_r[8*p];
            end else begin
                pix_bits_s[p] = shift_r[8*p+7];
            end
        end
    end

    // Fetch sequencer next state; any trigger restarts the fetch.
    always_comb begin
        state_nx_s = state_r;
        if (trigger_s) begin
            state_nx_s = MAP_RQ;
        end else begin
            case (state_r)
                IDLE:    state_nx_s = IDLE;
                MAP_RQ:  state_nx_s = MAP_WT;
                MAP_WT:  state_nx_s = ROM_RQ;
                ROM_RQ:  state_nx_s = ROM_WT;
                ROM_WT:  state_nx_s = IDLE;
                default: state_nx_s = IDLE;
            endcase
        end
    end

    // Fetch sequencer state register.
    always_ff @(posedge master_clk) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Memory addresses and fetched attributes; addresses are set on entry to
    // the request states so they are valid throughout them, and hold otherwise.
    always_ff @(posedge master_clk) begin
        if (reset) begin
            map_addr      <= '0;
            rom_addr      <= '0;
            vrow_r        <= 3'd0;
            fetch_color_r <= '0;
            fetch_hflip_r <= 1'b0;
        end else if (trigger_s) begin
            map_addr <= {vpix[MAP_ROWS_LOG2+2:3], hpix[MAP_COLS_LOG2+2:3]};
            vrow_r   <= vpix[2:0];
        end else if (state_r == MAP_WT) begin
            rom_addr      <= {map_tile_s, vrow_r ^ {3{map_vflip_s}}};
            fetch_color_r <= map_color_s;
            fetch_hflip_r <= map_hflip_s;
        end
    end

    // Prefetch buffer, tile load, pixel shifting and registered pixel outputs.
    always_ff @(posedge master_clk) begin
        if (reset) begin
            pre_valid_r    <= 1'b0;
            pre_data_r     <= '0;
            pre_color_r    <= '0;
            pre_hflip_r    <= 1'b0;
            shift_r        <= '0;
            cur_color_r    <= '0;
            cur_hflip_r    <= 1'b0;
            pixel_out      <= '0;
            pixel_opaque   <= 1'b0;
            fetch_underrun <= 1'b0;
        end else begin
            fetch_underrun <= 1'b0;
            // A new trigger makes any waiting prefetch stale.
            if (trigger_s) begin
                pre_valid_r <= 1'b0;
            end else if (capture_s && !load_s) begin
                pre_valid_r <= 1'b1;
                pre_data_r  <= rom_data;
                pre_color_r <= fetch_color_r;
                pre_hflip_r <= fetch_hflip_r;
            end else if (load_s) begin
                pre_valid_r <= 1'b0;
            end
            if (pixel_ce) begin
                if (layer_en) begin
                    pixel_out    <= {cur_color_r, pix_bits_s};
                    pixel_opaque <= (pix_bits_s != '0);
                end else begin
                    pixel_out    <= '0;
                    pixel_opaque <= 1'b0;
                end
                if (load_s) begin
                    if (capture_s) begin
                        shift_r     <= rom_data;
                        cur_color_r <= fetch_color_r;
                        cur_hflip_r <= fetch_hflip_r;
                    end else if (pre_valid_r) begin
                        shift_r     <= pre_data_r;
                        cur_color_r <= pre_color_r;
                        cur_hflip_r <= pre_hflip_r;
                    end else begin
                        shift_r        <= '0;
                        cur_color_r    <= '0;
                        cur_hflip_r    <= 1'b0;
                        fetch_underrun <= 1'b1;
                    end
                end else begin
                    shift_r <= shift_planes(shift_r, dir_right_s);
                end
            end
        end
    end

endmodule

// File: tb/tb_tile_layer_renderer.sv
// Self-checking bench for tile_layer_renderer: randomised tilemap/pattern memories
// plus directed tile patterns, checked every cycle against a behavioural model
// that tracks fetches by age and indexes tile rows arithmetically.
module tb_tile_layer_renderer;

    logic        master_clk;
    logic        reset;
    logic        pixel_ce;
    logic [8:0]  hpix;
    logic [7:0]  vpix;
    logic        screen_flip;
    logic        layer_en;
    logic [10:0] map_addr;
    logic [15:0] map_data;
    logic [12:0] rom_addr;
    logic [23:0] rom_data;
    logic [6:0]  pixel_out;
    logic        pixel_opaque;
    logic        fetch_underrun;

    tile_layer_renderer dut (
        .master_clk     (master_clk),
        .reset          (reset),
        .pixel_ce       (pixel_ce),
        .hpix           (hpix),
        .vpix           (vpix),
        .screen_flip    (screen_flip),
        .layer_en       (layer_en),
        .map_addr       (map_addr),
        .map_data       (map_data),
        .rom_addr       (rom_addr),
        .rom_data       (rom_data),
        .pixel_out      (pixel_out),
        .pixel_opaque   (pixel_opaque),
        .fetch_underrun (fetch_underrun)
    );

    logic [15:0] map_mem [0:2047];
    logic [23:0] rom_mem [0:8191];

    int checks = 0;
    int passes = 0;
    int fails  = 0;
    int ur_cnt = 0;
    logic [6:0] obs_q [$];

    // Model state
    int          age;
    logic [5:0]  f_h;
    logic [7:0]  f_v;
    logic        pv;
    logic [23:0] pv_bytes, cur_bytes;
    logic [3:0]  pv_col, cur_col;
    logic        pv_h, cur_h;
    int          k;
    logic [6:0]  exp_out;
    logic        exp_op, exp_ur;
    logic [10:0] exp_map;
    logic [12:0] exp_rom;

    initial master_clk = 1'b0;
    always #5 master_clk = ~master_clk;

    // Synchronous tilemap RAM and pattern ROM.
    always @(posedge master_clk) begin
        map_data <= map_mem[map_addr];
        rom_data <= rom_mem[rom_addr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    task automatic model_step();
        logic [2:0]  ph;
        logic        trig, load, cap, old_pv, dir;
        logic [15:0] w;
        logic [2:0]  row;
        logic [23:0] fb;
        logic [2:0]  bits;
        int          idx;
        if (reset) begin
            age = 0; pv = 1'b0; pv_bytes = 24'd0; pv_col = 4'd0; pv_h = 1'b0;
            cur_bytes = 24'd0; cur_col = 4'd0; cur_h = 1'b0; k = 8;
            exp_out = 7'd0; exp_op = 1'b0; exp_ur = 1'b0;
            exp_map = 11'd0; exp_rom = 13'd0;
        end else begin
            ph   = hpix[2:0] ^ {3{screen_flip}};
            trig = pixel_ce && (ph == 3'd0);
            load = pixel_ce && (ph == 3'd7);
            cap  = (age == 4) && !trig;
            w    = map_mem[{f_v[7:3], f_h}];
            row  = f_v[2:0] ^ {3{w[10]}};
            fb   = rom_mem[{w[9:0], row}];
            if (age == 2 && !trig) exp_rom = {w[9:0], row};
            if (trig) begin
                exp_map = {vpix[7:3], hpix[8:3]};
                f_h = hpix[8:3];
                f_v = vpix;
            end
            exp_ur = 1'b0;
            old_pv = pv;
            if (pixel_ce) begin
                dir = cur_h ^ screen_flip;
                idx = dir ? k : 7 - k;
                bits = 3'd0;
                if (k < 8) begin
                    for (int p = 0; p < 3; p++) bits[p] = cur_bytes[8*p + idx];
                end
                exp_out = layer_en ? {cur_col, bits} : 7'd0;
                exp_op  = layer_en && (bits != 3'd0);
                if (load) begin
                    if (cap) begin
                        cur_bytes = fb; cur_col = w[14:11]; cur_h = w[15];
                    end else if (old_pv) begin
                        cur_bytes = pv_bytes; cur_col = pv_col; cur_h = pv_h;
                    end else begin
                        cur_bytes = 24'd0; cur_col = 4'd0; cur_h = 1'b0; exp_ur = 1'b1;
                    end
                    k = 0;
                end else begin
                    k++;
                end
            end
            if (trig) pv = 1'b0;
            else if (cap && !load) begin
                pv = 1'b1; pv_bytes = fb; pv_col = w[14:11]; pv_h = w[15];
            end else if (load) pv = 1'b0;
            if (trig) age = 1;
            else if (age == 4) age = 0;
            else if (age > 0) age++;
        end
    endtask

    task automatic tick();
        @(posedge master_clk);
        model_step();
        #1;
        chk("pixel_out", 32'(pixel_out), 32'(exp_out));
        chk("pixel_opaque", 32'(pixel_opaque), 32'(exp_op));
        chk("fetch_underrun", 32'(fetch_underrun), 32'(exp_ur));
        chk("map_addr", 32'(map_addr), 32'(exp_map));
        chk("rom_addr", 32'(rom_addr), 32'(exp_rom));
        if (fetch_underrun) ur_cnt++;
        if (pixel_ce) obs_q.push_back(pixel_out);
    endtask

    task automatic pix(input int n, input int per, input logic [8:0] step);
        for (int i = 0; i < n; i++) begin
            pixel_ce = 1'b1;
            tick();
            pixel_ce = 1'b0;
            for (int j = 1; j < per; j++) tick();
            hpix = hpix + step;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        pixel_ce = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
        obs_q.delete();
        ur_cnt = 0;
    endtask

    initial begin
        reset = 1'b1; pixel_ce = 1'b0; hpix = 9'd0; vpix = 8'd0;
        screen_flip = 1'b0; layer_en = 1'b1;
        for (int i = 0; i < 2048; i++) map_mem[i] = 16'($urandom);
        for (int i = 0; i < 8192; i++) rom_mem[i] = 24'($urandom);
        map_mem[0] = 16'h2805;
        rom_mem[{10'd5, 3'd0}] = 24'hFF0080;
        rom_mem[{10'd5, 3'd7}] = 24'hFF0080;
        do_reset();

        // Random run, then reset in the middle of a fetch.
        pix(20, 1, 9'd1);
        hpix = 9'd24; pixel_ce = 1'b1; tick(); pixel_ce = 1'b0; tick();
        do_reset();
        repeat (4) tick();

        // Basic tile.
        hpix = 9'd0; vpix = 8'd0;
        pix(24, 4, 9'd1);
        chk("basic_first", 32'(obs_q[8]), 32'h2D);
        for (int i = 9; i < 16; i++) chk("basic_rest", 32'(obs_q[i]), 32'h2C);

        // Horizontal flip.
        map_mem[0] = 16'hA805;
        do_reset(); hpix = 9'd0;
        pix(24, 4, 9'd1);
        chk("hflip_first", 32'(obs_q[8]), 32'h2C);
        chk("hflip_last", 32'(obs_q[15]), 32'h2D);

        // Vertical flip: row 0 addresses pattern row 7.
        map_mem[0] = 16'h2C05;
        do_reset(); hpix = 9'd0;
        pix(2, 4, 9'd1);
        chk("vflip_rom_addr", 32'(rom_addr), 32'({10'd5, 3'd7}));
        pix(22, 4, 9'd1);
        chk("vflip_first", 32'(obs_q[8]), 32'h2D);

        // Screen flip with tile hflip cancels out; scan runs downward.
        map_mem[0] = 16'hA805;
        screen_flip = 1'b1;
        do_reset(); hpix = 9'd7;
        pix(24, 4, 9'h1FF);
        chk("sflip_first", 32'(obs_q[8]), 32'h2D);
        chk("sflip_second", 32'(obs_q[9]), 32'h2C);
        screen_flip = 1'b0;

        // Column wrap 511 -> 0 with random layer enable and lines.
        do_reset(); hpix = 9'd480; vpix = 8'($urandom);
        for (int i = 0; i < 12; i++) begin
            layer_en = ($urandom_range(0, 3) != 0);
            pix(8, 1, 9'd1);
        end
        layer_en = 1'b1;
        for (int l = 0; l < 4; l++) begin
            vpix = 8'($urandom);
            hpix = {6'($urandom), 3'd0};
            pix(40, 2, 9'd1);
        end

        // layer_en dropped mid-tile, then restored.
        do_reset(); hpix = 9'd0; vpix = 8'd0;
        pix(11, 2, 9'd1);
        layer_en = 1'b0;
        pix(3, 2, 9'd1);
        layer_en = 1'b1;
        pix(10, 2, 9'd1);
        chk("layer_off", 32'(obs_q[11]), 32'h0);

        // Underrun: restart trigger one cycle before the tile load.
        do_reset(); hpix = 9'd0; vpix = 8'd40;
        pix(14, 1, 9'd1);
        hpix = 9'd16; pixel_ce = 1'b1; tick();
        hpix = 9'd15; tick();
        hpix = 9'd16;
        pix(20, 1, 9'd1);
        chk("underrun_count", 32'(ur_cnt), 32'd1);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
